leaky_relu_stream: RTL and testbench

//  Streaming, backpressured successor to the flat leaky-ReLU array. Consumes LANES

---
 rtl/leaky_relu_stream_pkg.sv | 47 ++++
 rtl/leaky_relu_stream_lane.sv | 79 +++++++
 rtl/leaky_relu_stream.sv | 183 ++++++++++++++++++
 tb/tb_leaky_relu_stream.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaky_relu_stream_pkg.sv
// Shared definitions for the leaky-ReLU streaming block.
//  - MODE_* : activation mode encodings carried on cfg_mode.
//  - lane_kind_e : what stage 2 of a lane does with the stage-1 result.
//  - round_sat : round-half-up arithmetic shift plus saturation of a
//    fixed-point product to a signed data_w-bit result. It works on a
//    fixed-width container, so DATA_WIDTH+SLOPE_WIDTH must not exceed
//    RS_PROD_W and DATA_WIDTH must not exceed RS_RES_W. FRAC_WIDTH must be >= 1.
package leaky_relu_stream_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_RELU   = 2'd1;
    localparam logic [1:0] MODE_LEAKY  = 2'd2;
    localparam logic [1:0] MODE_PRELU  = 2'd3;

    typedef enum logic [1:0] {
        KIND_PASS  = 2'd0,
        KIND_ZERO  = 2'd1,
        KIND_SCALE = 2'd2
    } lane_kind_e;

    localparam int RS_PROD_W = 96;
    localparam int RS_RES_W  = 64;

    function automatic logic signed [RS_RES_W-1:0] round_sat(
        input logic signed [RS_PROD_W-1:0] prod,
        input int                          frac_w,
        input int                          data_w
    );
        logic signed [RS_PROD_W-1:0] half_v;
        logic signed [RS_PROD_W-1:0] rnd_v;
        logic signed [RS_PROD_W-1:0] max_v;
        logic signed [RS_PROD_W-1:0] min_v;
        half_v = 96'sd1 <<< (frac_w - 1);
        // Arithmetic shift floors, so adding half first rounds half up.
        rnd_v  = (prod + half_v) >>> frac_w;
        max_v  = (96'sd1 <<< (data_w - 1)) - 96'sd1;
        min_v  = -(96'sd1 <<< (data_w - 1));
        if (rnd_v > max_v) begin
            return RS_RES_W'(max_v);
        end else if (rnd_v < min_v) begin
            return RS_RES_W'(min_v);
        end else begin
            return RS_RES_W'(rnd_v);
        end
    endfunction

endpackage

// File: rtl/leaky_relu_stream_lane.sv
// One activation lane of leaky_relu_stream.
//  Stage 1 registers the raw input, the full-width product x*slope and the
//  kind of result wanted; stage 2 registers the final DATA_WIDTH result.
//  Both stages advance only when en is high, so the whole pipeline stalls
//  as a unit under backpressure.
// Ports:
//  clk, rst_n : clock, async active-low reset
//  en         : pipeline advance enable shared by all lanes
//  mode       : activation mode for the beat entering stage 1
//  slope      : slope for the beat entering stage 1
//  x          : input activation
//  y          : registered result (stage 2 output)
module leaky_relu_lane
    import leaky_relu_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_WIDTH  = 8,
    parameter int SLOPE_WIDTH = 16
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic signed [SLOPE_WIDTH-1:0] slope,
    input  logic signed [DATA_WIDTH-1:0]  x,
    output logic signed [DATA_WIDTH-1:0]  y
);
    localparam int PW = DATA_WIDTH + SLOPE_WIDTH;

    logic signed [DATA_WIDTH-1:0] x_q,    x_d;
    logic signed [PW-1:0]         prod_q, prod_d;
    lane_kind_e                   kind_q, kind_d;
    logic signed [DATA_WIDTH-1:0] y_q,    y_d;

    // Next-state for both stages; everything holds when en is low.
    always_comb begin
        x_d    = x_q;
        prod_d = prod_q;
        kind_d = kind_q;
        y_d    = y_q;
        if (en) begin
            x_d    = x;
            prod_d = PW'(x) * PW'(slope);
            if (!x[DATA_WIDTH-1] || (mode == MODE_BYPASS)) begin
                kind_d = KIND_PASS;
            end else if (mode == MODE_RELU) begin
                kind_d = KIND_ZERO;
            end else begin
                kind_d = KIND_SCALE;
            end
            case (kind_q)
                KIND_PASS:  y_d = x_q;
                KIND_ZERO:  y_d = '0;
                KIND_SCALE: y_d = DATA_WIDTH'(round_sat(RS_PROD_W'(prod_q), FRAC_WIDTH, DATA_WIDTH));
                default:    y_d = '0;
            endcase
        end else begin
            y_d = y_q;
        end
    end

    // Stage 1 and stage 2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            prod_q <= '0;
            kind_q <= KIND_PASS;
            y_q    <= '0;
        end else begin
            x_q    <= x_d;
            prod_q <= prod_d;
            kind_q <= kind_d;
            y_q    <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/leaky_relu_stream.sv
// Streaming leaky-ReLU / PReLU stage with valid/ready handshakes.
//  Accepts LANES activations per beat, applies bypass / ReLU / leaky / PReLU
//  and emits the result two cycles later tagged with channel and end-of-frame.
//  Owns the beat/channel counters, the per-channel slope table, the frame
//  mode register and the two-stage valid pipeline; the arithmetic lives in
//  leaky_relu_lane, instantiated once per lane.
// Ports:
//  cfg_mode                 activation mode, sampled at the first beat of a frame
//  cfg_slope_we/addr/data   slope table write port
//  s_valid/s_ready/s_data   input stream
//  m_valid/m_ready/m_data   output stream, m_chan channel tag, m_last frame end
module leaky_relu_stream
    import leaky_relu_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FRAC_WIDTH    = 8,
    parameter int SLOPE_WIDTH   = 16,
    parameter int LANES         = 4,
    parameter int CHANNELS      = 8,
    parameter int BEATS_PER_CH  = 4,
    parameter int DEFAULT_SLOPE = 3,
    // Derived from CHANNELS; leave at its default.
    parameter int CH_AW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  cfg_mode,
    input  logic                        cfg_slope_we,
    input  logic [CH_AW-1:0]            cfg_slope_addr,
    input  logic [SLOPE_WIDTH-1:0]      cfg_slope_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*DATA_WIDTH-1:0] s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [LANES*DATA_WIDTH-1:0] m_data,
    output logic [CH_AW-1:0]            m_chan,
    output logic                        m_last
);
    localparam int                 BEAT_AW  = (BEATS_PER_CH > 1) ? $clog2(BEATS_PER_CH) : 1;
    localparam logic [BEAT_AW-1:0] BEAT_MAX = BEAT_AW'(BEATS_PER_CH - 1);
    localparam logic [CH_AW-1:0]   CHAN_MAX = CH_AW'(CHANNELS - 1);

    logic                          adv_s;
    logic                          acc_s;
    logic                          first_s;
    logic                          last_s;
    logic [1:0]                    beat_mode_s;
    logic signed [SLOPE_WIDTH-1:0] beat_slope_s;

    logic [BEAT_AW-1:0]     beat_q,       beat_d;
    logic [CH_AW-1:0]       chan_q,       chan_d;
    logic [1:0]             frame_mode_q, frame_mode_d;
    logic                   s1_valid_q,   s1_valid_d;
    logic [CH_AW-1:0]       s1_chan_q,    s1_chan_d;
    logic                   s1_last_q,    s1_last_d;
    logic                   m_valid_q,    m_valid_d;
    logic [CH_AW-1:0]       m_chan_q,     m_chan_d;
    logic                   m_last_q,     m_last_d;
    logic [SLOPE_WIDTH-1:0] slope_q [CHANNELS];
    logic [SLOPE_WIDTH-1:0] slope_d [CHANNELS];

    // The whole pipeline moves whenever the output register is free or draining.
    assign adv_s   = !m_valid_q || m_ready;
    assign acc_s   = s_valid && adv_s;
    assign s_ready = adv_s;

    assign first_s = (beat_q == '0) && (chan_q == '0);
    assign last_s  = (beat_q == BEAT_MAX) && (chan_q == CHAN_MAX);

    // A new frame takes cfg_mode live; later beats reuse the latched frame mode.
    assign beat_mode_s  = first_s ? cfg_mode : frame_mode_q;
    assign beat_slope_s = (beat_mode_s == MODE_PRELU) ? slope_q[chan_q] : slope_q[0];

    // Beat/channel counters, frame mode and valid/tag pipeline next-state.
    always_comb begin
        beat_d       = beat_q;
        chan_d       = chan_q;
        frame_mode_d = frame_mode_q;
        s1_valid_d   = s1_valid_q;
        s1_chan_d    = s1_chan_q;
        s1_last_d    = s1_last_q;
        m_valid_d    = m_valid_q;
        m_chan_d     = m_chan_q;
        m_last_d     = m_last_q;
        if (acc_s) begin
            frame_mode_d = beat_mode_s;
            if (beat_q == BEAT_MAX) begin
                beat_d = '0;
                if (chan_q == CHAN_MAX) begin
                    chan_d = '0;
                end else begin
                    chan_d = chan_q + CH_AW'(1);
                end
            end else begin
                beat_d = beat_q + BEAT_AW'(1);
            end
        end else begin
            beat_d = beat_q;
        end
        if (adv_s) begin
            s1_valid_d = s_valid;
            s1_chan_d  = chan_q;
            s1_last_d  = last_s;
            m_valid_d  = s1_valid_q;
            m_chan_d   = s1_chan_q;
            m_last_d   = s1_last_q;
        end else begin
            m_valid_d  = m_valid_q;
        end
    end

    // Slope table write; the write lands on the edge, so a beat accepted on the
    // same edge has already read the old entry.
    always_comb begin
        slope_d = slope_q;
        if (cfg_slope_we && ({{(32-CH_AW){1'b0}}, cfg_slope_addr} < 32'(CHANNELS))) begin
            slope_d[cfg_slope_addr] = cfg_slope_data;
        end else begin
            slope_d = slope_q;
        end
    end

    // Control and tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q       <= '0;
            chan_q       <= '0;
            frame_mode_q <= MODE_BYPASS;
            s1_valid_q   <= 1'b0;
            s1_chan_q    <= '0;
            s1_last_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_chan_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            chan_q       <= chan_d;
            frame_mode_q <= frame_mode_d;
            s1_valid_q   <= s1_valid_d;
            s1_chan_q    <= s1_chan_d;
            s1_last_q    <= s1_last_d;
            m_valid_q    <= m_valid_d;
            m_chan_q     <= m_chan_d;
            m_last_q     <= m_last_d;
        end
    end

    // Slope table registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                slope_q[i] <= SLOPE_WIDTH'(DEFAULT_SLOPE);
            end
        end else begin
            slope_q <= slope_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            leaky_relu_lane #(
                .DATA_WIDTH  (DATA_WIDTH),
                .FRAC_WIDTH  (FRAC_WIDTH),
                .SLOPE_WIDTH (SLOPE_WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (adv_s),
                .mode  (beat_mode_s),
                .slope (beat_slope_s),
                .x     (s_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .y     (m_data[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    assign m_valid = m_valid_q;
    assign m_chan  = m_chan_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_leaky_relu_stream.sv
// Scoreboard bench for leaky_relu_stream (default parameters).
module tb_leaky_relu_stream;
    localparam int CH  = 8;
    localparam int BPC = 4;

    typedef struct packed {
        logic [127:0] d;
        logic [2:0]   ch;
        logic         last;
        logic         lat;
        logic [31:0]  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   cfg_mode;
    logic         cfg_slope_we;
    logic [2:0]   cfg_slope_addr;
    logic [15:0]  cfg_slope_data;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [2:0]   m_chan;
    logic         m_last;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   tb_beat = 0;
    int   tb_chan = 0;
    bit   pw_en = 1'b0;
    logic [2:0]  pw_addr = 3'd0;
    logic [15:0] pw_data = 16'd0;

    leaky_relu_stream dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_mode       (cfg_mode),
        .cfg_slope_we   (cfg_slope_we),
        .cfg_slope_addr (cfg_slope_addr),
        .cfg_slope_data (cfg_slope_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_chan         (m_chan),
        .m_last         (m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one beat; push its expectation when the handshake is seen.
    task automatic send(input logic [127:0] din, input logic [127:0] dexp, input bit lat);
        int   tries;
        exp_t e;
        tries = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = din;
        if (pw_en) begin
            cfg_slope_we   = 1'b1;
            cfg_slope_addr = pw_addr;
            cfg_slope_data = pw_data;
            pw_en          = 1'b0;
        end
        #4;
        while (!s_ready && tries < 200) begin
            @(negedge clk);
            #4;
            tries++;
        end
        if (!s_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end else begin
            e.d    = dexp;
            e.ch   = 3'(tb_chan);
            e.last = (tb_beat == BPC - 1) && (tb_chan == CH - 1);
            e.lat  = lat;
            e.cyc  = 32'(cyc);
            sb_q.push_back(e);
            if (tb_beat == BPC - 1) begin
                tb_beat = 0;
                tb_chan = (tb_chan == CH - 1) ? 0 : tb_chan + 1;
            end else begin
                tb_beat++;
            end
        end
        @(posedge clk);
        #1;
        s_valid      = 1'b0;
        cfg_slope_we = 1'b0;
    endtask

    task automatic write_slope(input logic [2:0] a, input logic [15:0] v);
        @(negedge clk);
        cfg_slope_we   = 1'b1;
        cfg_slope_addr = a;
        cfg_slope_data = v;
        @(negedge clk);
        cfg_slope_we   = 1'b0;
    endtask

    task automatic drain();
        int tries;
        tries = 0;
        while (sb_q.size() != 0 && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        check("drain", 128'(sb_q.size()), 128'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: sample just before each rising edge, compare on handshake,
    // check hold behaviour while stalled.
    initial begin : monitor
        exp_t         e;
        logic [127:0] held_d;
        logic [2:0]   held_ch;
        logic         held_last;
        bit           held_v;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n === 1'b1) begin
                if (m_valid && m_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %h expected none", m_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("m_data", m_data, e.d);
                        check("m_chan", 128'(m_chan), 128'(e.ch));
                        check("m_last", 128'(m_last), 128'(e.last));
                        if (e.lat) check("latency", 128'(cyc - int'(e.cyc)), 128'd2);
                    end
                    held_v = 1'b0;
                end else if (m_valid) begin
                    check("s_ready_stall", 128'(s_ready), 128'd0);
                    if (held_v) begin
                        check("hold_data", m_data, held_d);
                        check("hold_chan", 128'(m_chan), 128'(held_ch));
                        check("hold_last", 128'(m_last), 128'(held_last));
                    end
                    held_d    = m_data;
                    held_ch   = m_chan;
                    held_last = m_last;
                    held_v    = 1'b1;
                end else begin
                    held_v = 1'b0;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n          = 1'b0;
        cfg_mode       = 2'd0;
        cfg_slope_we   = 1'b0;
        cfg_slope_addr = 3'd0;
        cfg_slope_data = 16'd0;
        s_valid        = 1'b0;
        s_data         = 128'd0;
        m_ready        = 1'b1;
        #12;
        check("rst_m_valid", 128'(m_valid), 128'd0);
        check("rst_m_data", m_data, 128'd0);
        check("rst_m_chan", 128'(m_chan), 128'd0);
        check("rst_m_last", 128'(m_last), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_s_ready", 128'(s_ready), 128'd1);

        // 1: leaky with default slope 3
        cfg_mode = 2'd2;
        for (int i = 0; i < 32; i++)
            send(pk(-256, 1000, -1, -100), pk(-3, 1000, 0, -1), 1'b1);
        drain();

        // 2: ReLU, with a mid-frame mode change that must be ignored; then bypass
        cfg_mode = 2'd1;
        send(pk(-5, 0, 7, -1), pk(0, 0, 7, 0), 1'b1);
        cfg_mode = 2'd0;
        for (int i = 1; i < 32; i++)
            send(pk(-5, 0, 7, -1), pk(0, 0, 7, 0), 1'b1);
        drain();
        for (int i = 0; i < 32; i++)
            send(pk(-5, 0, 7, -1), pk(-5, 0, 7, -1), 1'b1);
        drain();

        // 3: PReLU with slope[2] = 0.5
        write_slope(3'd2, 16'd128);
        cfg_mode = 2'd3;
        for (int i = 0; i < 32; i++) begin
            if (tb_chan == 2) send(pk(-512, -512, -512, -512), pk(-256, -256, -256, -256), 1'b1);
            else              send(pk(-512, -512, -512, -512), pk(-6, -6, -6, -6), 1'b1);
        end
        drain();

        // 4: leaky saturation; slope[0] write lands with the first beat, which keeps slope 3
        cfg_mode = 2'd2;
        pw_en    = 1'b1;
        pw_addr  = 3'd0;
        pw_data  = 16'h7FFF;
        send(pk(-256, 0, 0, 0), pk(-3, 0, 0, 0), 1'b1);
        for (int i = 1; i < 32; i++)
            send(pk(32'h80000000, -1, 256, -256), pk(32'h80000000, -128, 256, -32767), 1'b1);
        drain();

        // 5: backpressure during a bypass burst
        cfg_mode = 2'd0;
        fork
            begin
                for (int k = 0; k < 32; k++)
                    send(pk(k, -k - 1, k * 256, 1000 + k), pk(k, -k - 1, k * 256, 1000 + k), 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                m_ready = 1'b0;
                #4;
                check("bp_s_ready", 128'(s_ready), 128'd0);
                repeat (5) @(negedge clk);
                m_ready = 1'b1;
            end
        join
        drain();

        // 6: reset in the middle of channel 3, then a fresh PReLU frame
        cfg_mode = 2'd3;
        for (int i = 0; i < 14; i++) begin
            if (tb_chan == 0)      send(pk(-512, -512, -512, -512), pk(-65534, -65534, -65534, -65534), 1'b1);
            else if (tb_chan == 2) send(pk(-512, -512, -512, -512), pk(-256, -256, -256, -256), 1'b1);
            else                   send(pk(-512, -512, -512, -512), pk(-6, -6, -6, -6), 1'b1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 128'(m_valid), 128'd0);
        check("midrst_m_data", m_data, 128'd0);
        check("midrst_m_chan", 128'(m_chan), 128'd0);
        sb_q.delete();
        tb_beat = 0;
        tb_chan = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++)
            send(pk(-512, -512, -512, -512), pk(-6, -6, -6, -6), 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
